snn_axil_param_slave: RTL and testbench
=======================================

Name: snn_axil_param_slave

Overview:
AXI4-Lite slave register bank for the SNN processor. It is the responder end of the bus that the block-design AXI masters drive for the CONTROLS, SYNAPSES and PARAMSPACE windows.
- Holds NUM_REGS 32-bit words: a control register, a read-only status register, and general parameter words.
- Gives the SNN core a start pulse, a sticky done flag and a 1-cycle-latency read port into the parameter words.

Parameters:
DATA_WIDTH, 32, AXI data width; fixed at 32, other values unsupported.
ADDR_WIDTH, 8, AXI byte-address width.
NUM_REGS, 16, number of 32-bit words; word index = addr[ADDR_WIDTH-1:2]; must be >=3 and <=2^(ADDR_WIDTH-2).

Ports:
ACLK  in  1  clock; all logic on rising edge
ARESET  in  1  synchronous reset, active-high
S_AXI_AWADDR  in  ADDR_WIDTH  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID  in  1  write-address valid
S_AXI_AWREADY  out  1  write-address ready
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte strobes
S_AXI_WVALID  in  1  write-data valid
S_AXI_WREADY  out  1  write-data ready
S_AXI_BRESP  out  2  write response
S_AXI_BVALID  out  1  write-response valid
S_AXI_BREADY  in  1  write-response ready
S_AXI_ARADDR  in  ADDR_WIDTH  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID  in  1  read-address valid
S_AXI_ARREADY  out  1  read-address ready
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID  out  1  read valid
S_AXI_RREADY  in  1  read ready
core_start  out  1  one-cycle start pulse to the SNN core
core_busy  in  1  core busy level
core_done  in  1  core done pulse
core_rd_addr  in  clog2(NUM_REGS)  core-side word index
core_rd_data  out  32  core-side read data, 1-cycle latency

Behaviour:
Reset:
- Synchronous, active-high; ARESET=1 at a clock edge clears everything.
- All outputs go to 0, both FSMs go to idle, all registers and the done flag go to 0.
- Any in-flight transaction is dropped without a response.

Register map:
- 0 CTRL: bit0 START is write-1-pulse (reads 0). bit1 DONE_CLR is write-1-pulse (reads 0). Bits 31:2 are R/W storage.
- 1 STATUS: read-only, {30'b0, done_flag, core_busy}. Writes are ignored and return OKAY.
- 2..NUM_REGS-1: R/W parameter words.
- Index >= NUM_REGS: SLVERR (2'b10); write is discarded; RDATA=0.
- addr[1:0] is ignored.

Write FSM (states W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP):
- Readies are registered state decodes. AWREADY=1 in W_IDLE and W_HAVE_D. WREADY=1 in W_IDLE and W_HAVE_A.
- W_IDLE: AW and W handshake in the same cycle -> commit, go to W_RESP. AW only -> latch address, go to W_HAVE_A. W only -> latch data and strobes, go to W_HAVE_D.
- W_HAVE_A + W handshake, or W_HAVE_D + AW handshake -> commit, go to W_RESP.
- Commit edge: bytes with WSTRB[i]=1 are updated. BVALID=1 and BRESP are valid from the next cycle.
- W_RESP: BVALID held until BREADY=1, then W_IDLE. Minimum 2 cycles per write.
- START: core_start=1 for exactly the one cycle after a commit to CTRL with WSTRB[0]=1 and WDATA[0]=1.

Read FSM (states R_IDLE, R_RESP):
- ARREADY=1 only in R_IDLE.
- AR handshake: register value is sampled on that edge into RDATA/RRESP. RVALID=1 next cycle.
- RVALID, RDATA and RRESP are held stable until RREADY=1, then R_IDLE.
- Read and write FSMs are independent.
- AR handshake on the same edge as a write commit to the same word returns the pre-write value.

Done flag:
- core_done=1 sets done_flag.
- A CTRL commit with DONE_CLR=1 clears it.
- Set and clear on the same edge: set wins.

Core read port:
- core_rd_data on cycle n+1 equals word[core_rd_addr] at edge n.
- Write commits are visible on the port from the cycle after the commit edge.

Test Plan:
- Write 0x1,0x2,0x3,0x4 to 0x08,0x0C,0x10,0x14, then read back -> RDATA matches each value, RRESP=0 and BRESP=0 on every transaction.
- AW driven 3 cycles before W to 0x08, data 0xDEADBEEF -> AWREADY drops after the AW handshake; BVALID one cycle after the W handshake; reading 0x08 returns 0xDEADBEEF. Repeat with W before AW -> same result.
- Write 0x11223344 to 0x0C, then write 0xAABBCCDD with WSTRB=4'b0101 -> read 0x0C = 0x11BB33DD.
- Write 0x1 to 0x00 -> core_start high for exactly 1 cycle; read 0x00 bit0 = 0. Pulse core_done -> read 0x04 = 0x2. Write 0x2 to 0x00 together with a same-edge core_done -> flag stays set, 0x04 reads 0x2.
- Write then read 0x40 -> BRESP=2'b10, RRESP=2'b10, RDATA=0; words 0..15 unchanged.
- Hold BREADY and RREADY low for 5 cycles -> BVALID, RVALID and RDATA stable, no new AW/AR accepted. Assert ARESET mid-write -> all outputs 0 next cycle and no BVALID is issued.

Source files
------------

// File: rtl/snn_axil_param_slave.sv
// AXI4-Lite register bank for the SNN processor: CTRL/STATUS/parameter words,
// a start pulse and sticky done flag for the core, and a core-side read port.
module snn_axil_param_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_REGS   = 16
) (
  input  logic                        ACLK,
  input  logic                        ARESET,
  input  logic [ADDR_WIDTH-1:0]       S_AXI_AWADDR,
  input  logic [2:0]                  S_AXI_AWPROT,
  input  logic                        S_AXI_AWVALID,
  output logic                        S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]       S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]     S_AXI_WSTRB,
  input  logic                        S_AXI_WVALID,
  output logic                        S_AXI_WREADY,
  output logic [1:0]                  S_AXI_BRESP,
  output logic                        S_AXI_BVALID,
  input  logic                        S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]       S_AXI_ARADDR,
  input  logic [2:0]                  S_AXI_ARPROT,
  input  logic                        S_AXI_ARVALID,
  output logic                        S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]       S_AXI_RDATA,
  output logic [1:0]                  S_AXI_RRESP,
  output logic                        S_AXI_RVALID,
  input  logic                        S_AXI_RREADY,
  output logic                        core_start,
  input  logic                        core_busy,
  input  logic                        core_done,
  input  logic [$clog2(NUM_REGS)-1:0] core_rd_addr,
  output logic [DATA_WIDTH-1:0]       core_rd_data
);

  localparam int NB      = DATA_WIDTH / 8;
  localparam int IDX_W   = ADDR_WIDTH - 2;
  localparam int CORE_AW = $clog2(NUM_REGS);
  localparam logic [IDX_W:0]   NUM_REGS_L = NUM_REGS[IDX_W:0];
  localparam logic [IDX_W-1:0] IDX_CTRL   = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_STATUS = IDX_W'(1);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_RESP} r_state_e;

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;
  logic awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [1:0] bresp_q, bresp_d, rresp_q, rresp_d;
  logic arready_q, arready_d, rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d, wdata_q, wdata_d;
  logic [NB-1:0] wstrb_q, wstrb_d;
  logic [IDX_W-1:0] waddr_q, waddr_d;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
  logic done_q, done_d, core_start_q, core_start_d;
  logic [DATA_WIDTH-1:0] core_rd_data_q, core_rd_data_d;

  logic                  commit_en;
  logic [IDX_W-1:0]      commit_idx;
  logic [DATA_WIDTH-1:0] commit_data;
  logic [NB-1:0]         commit_strb;
  logic                  ctrl_hit;

  logic aw_hs, w_hs, ar_hs;
  logic [IDX_W-1:0] aw_idx, ar_idx;
  logic unused_bits;

  assign aw_hs  = S_AXI_AWVALID & awready_q;
  assign w_hs   = S_AXI_WVALID & wready_q;
  assign ar_hs  = S_AXI_ARVALID & arready_q;
  assign aw_idx = S_AXI_AWADDR[ADDR_WIDTH-1:2];
  assign ar_idx = S_AXI_ARADDR[ADDR_WIDTH-1:2];
  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  function automatic logic in_range(input logic [IDX_W-1:0] idx);
    return ({1'b0, idx} < NUM_REGS_L);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] word_value(
      input logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs,
      input logic done, input logic busy, input logic [IDX_W-1:0] idx);
    logic [DATA_WIDTH-1:0] val;
    val = '0;
    if (idx == IDX_STATUS) begin
      val[1] = done;
      val[0] = busy;
    end else if (in_range(idx)) begin
      val = regs[idx[CORE_AW-1:0]];
    end
    return val;
  endfunction

  // Write channel: collect AW and W in either order, commit once both are in, then hold B.
  always_comb begin
    w_state_d   = w_state_q;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    bresp_d     = bresp_q;
    commit_en   = 1'b0;
    commit_idx  = waddr_q;
    commit_data = wdata_q;
    commit_strb = wstrb_q;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          commit_en   = 1'b1;
          commit_idx  = aw_idx;
          commit_data = S_AXI_WDATA;
          commit_strb = S_AXI_WSTRB;
          w_state_d   = W_RESP;
        end else if (aw_hs) begin
          waddr_d   = aw_idx;
          w_state_d = W_HAVE_A;
        end else if (w_hs) begin
          wdata_d   = S_AXI_WDATA;
          wstrb_d   = S_AXI_WSTRB;
          w_state_d = W_HAVE_D;
        end
      end
      W_HAVE_A: begin
        if (w_hs) begin
          commit_en   = 1'b1;
          commit_data = S_AXI_WDATA;
          commit_strb = S_AXI_WSTRB;
          w_state_d   = W_RESP;
        end
      end
      W_HAVE_D: begin
        if (aw_hs) begin
          commit_en  = 1'b1;
          commit_idx = aw_idx;
          w_state_d  = W_RESP;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
    if (commit_en) bresp_d = in_range(commit_idx) ? RESP_OKAY : RESP_SLVERR;
    awready_d = (w_state_d == W_IDLE) || (w_state_d == W_HAVE_D);
    wready_d  = (w_state_d == W_IDLE) || (w_state_d == W_HAVE_A);
    bvalid_d  = (w_state_d == W_RESP);
  end

  // Register file update, CTRL pulse bits, done flag and the core read port.
  always_comb begin
    regs_d = regs_q;
    if (commit_en && in_range(commit_idx) && (commit_idx != IDX_STATUS)) begin
      for (int b = 0; b < NB; b++) begin
        if (commit_strb[b]) regs_d[commit_idx[CORE_AW-1:0]][8*b +: 8] = commit_data[8*b +: 8];
      end
    end
    regs_d[0][1:0] = 2'b00;
    regs_d[1]      = '0;
    ctrl_hit       = commit_en && (commit_idx == IDX_CTRL) && commit_strb[0];
    core_start_d   = ctrl_hit && commit_data[0];
    done_d         = core_done | (done_q & ~(ctrl_hit & commit_data[1]));
    core_rd_data_d = word_value(regs_d, done_d, core_busy, IDX_W'(core_rd_addr));
  end

  // Read channel: sample the addressed word on the AR handshake and hold it until RREADY.
  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          rdata_d   = word_value(regs_q, done_q, core_busy, ar_idx);
          rresp_d   = in_range(ar_idx) ? RESP_OKAY : RESP_SLVERR;
          r_state_d = R_RESP;
        end
      end
      R_RESP: begin
        if (S_AXI_RREADY) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
    rvalid_d  = (r_state_d == R_RESP);
  end

  // State and registered outputs; reset drops any in-flight transaction.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state_q      <= W_IDLE;
      r_state_q      <= R_IDLE;
      awready_q      <= 1'b0;
      wready_q       <= 1'b0;
      bvalid_q       <= 1'b0;
      bresp_q        <= 2'b00;
      arready_q      <= 1'b0;
      rvalid_q       <= 1'b0;
      rdata_q        <= '0;
      rresp_q        <= 2'b00;
      waddr_q        <= '0;
      wdata_q        <= '0;
      wstrb_q        <= '0;
      regs_q         <= '0;
      done_q         <= 1'b0;
      core_start_q   <= 1'b0;
      core_rd_data_q <= '0;
    end else begin
      w_state_q      <= w_state_d;
      r_state_q      <= r_state_d;
      awready_q      <= awready_d;
      wready_q       <= wready_d;
      bvalid_q       <= bvalid_d;
      bresp_q        <= bresp_d;
      arready_q      <= arready_d;
      rvalid_q       <= rvalid_d;
      rdata_q        <= rdata_d;
      rresp_q        <= rresp_d;
      waddr_q        <= waddr_d;
      wdata_q        <= wdata_d;
      wstrb_q        <= wstrb_d;
      regs_q         <= regs_d;
      done_q         <= done_d;
      core_start_q   <= core_start_d;
      core_rd_data_q <= core_rd_data_d;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign core_start    = core_start_q;
  assign core_rd_data  = core_rd_data_q;

endmodule

// File: tb/tb_snn_axil_param_slave.sv
// Testbench for snn_axil_param_slave: table of write/read-back vectors plus
// hand sequences for split handshakes, start/done, backpressure and reset.
module tb_snn_axil_param_slave;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [7:0]  S_AXI_AWADDR;
  logic [2:0]  S_AXI_AWPROT;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [7:0]  S_AXI_ARADDR;
  logic [2:0]  S_AXI_ARPROT;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;
  logic        core_start;
  logic        core_busy;
  logic        core_done;
  logic [3:0]  core_rd_addr;
  logic [31:0] core_rd_data;

  snn_axil_param_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .NUM_REGS(16)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .core_start(core_start), .core_busy(core_busy), .core_done(core_done),
    .core_rd_addr(core_rd_addr), .core_rd_data(core_rd_data)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_bresp;
    logic [1:0]  exp_rresp;
  } vec_t;

  vec_t        vecs[12];
  logic [31:0] model_mem[16];
  int          n_checks = 0;
  int          n_fail = 0;
  int          start_cnt = 0;

  // Count every cycle in which the start pulse is high.
  always @(negedge ACLK) if (core_start) start_cnt++;

  // Hard stop in case the run wanders off.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic checkBit(input string name, input logic actual, input logic expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
    end
  endtask

  task automatic model_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb);
    logic [5:0] idx;
    idx = addr[7:2];
    if (idx < 6'd16 && idx != 6'd1) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) model_mem[idx[3:0]][8*b +: 8] = data[8*b +: 8];
    end
    model_mem[0][1:0] = 2'b00;
  endtask

  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp);
    logic aw_done, w_done, aw_now, w_now;
    int cyc;
    S_AXI_AWADDR = addr; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = data; S_AXI_WSTRB = strb; S_AXI_WVALID = 1'b1;
    aw_done = 1'b0; w_done = 1'b0; cyc = 0;
    while (!(aw_done && w_done) && cyc < 20) begin
      aw_now = S_AXI_AWVALID && S_AXI_AWREADY;
      w_now  = S_AXI_WVALID && S_AXI_WREADY;
      tick();
      cyc++;
      if (aw_now) begin aw_done = 1'b1; S_AXI_AWVALID = 1'b0; end
      if (w_now)  begin w_done = 1'b1;  S_AXI_WVALID = 1'b0; end
    end
    if (!(aw_done && w_done)) begin
      checkBit("wr_handshake_timeout", 1'b0, 1'b1);
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; resp = 2'b11;
      return;
    end
    cyc = 0;
    while (!S_AXI_BVALID && cyc < 20) begin tick(); cyc++; end
    if (!S_AXI_BVALID) begin
      checkBit("bvalid_timeout", 1'b0, 1'b1);
      resp = 2'b11;
      return;
    end
    resp = S_AXI_BRESP;
    S_AXI_BREADY = 1'b1;
    tick();
    S_AXI_BREADY = 1'b0;
    model_write(addr, data, strb);
  endtask

  task automatic axi_read(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int cyc;
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1; cyc = 0;
    while (!S_AXI_ARREADY && cyc < 20) begin tick(); cyc++; end
    tick();
    S_AXI_ARVALID = 1'b0;
    cyc = 0;
    while (!S_AXI_RVALID && cyc < 20) begin tick(); cyc++; end
    if (!S_AXI_RVALID) begin
      checkBit("rvalid_timeout", 1'b0, 1'b1);
      data = 32'hxxxxxxxx; resp = 2'b11;
      return;
    end
    data = S_AXI_RDATA; resp = S_AXI_RRESP;
    S_AXI_RREADY = 1'b1;
    tick();
    S_AXI_RREADY = 1'b0;
  endtask

  task automatic readCheck(input string name, input logic [7:0] addr, input logic [31:0] expected);
    logic [31:0] d;
    logic [1:0]  r;
    axi_read(addr, d, r);
    checkOutput({name, "_rdata"}, d, expected);
    checkOutput({name, "_rresp"}, 32'(r), 32'h0);
  endtask

  task automatic applyStimulus(input int i, input vec_t v);
    logic [1:0]  r;
    logic [31:0] d;
    axi_write(v.addr, v.wdata, v.wstrb, r);
    checkOutput($sformatf("vec%0d_bresp", i), 32'(r), 32'(v.exp_bresp));
    axi_read(v.addr, d, r);
    checkOutput($sformatf("vec%0d_rdata", i), d, v.exp_rdata);
    checkOutput($sformatf("vec%0d_rresp", i), 32'(r), 32'(v.exp_rresp));
  endtask

  task automatic checkResetOutputs(input string tag);
    checkBit({tag, "_awready"}, S_AXI_AWREADY, 1'b0);
    checkBit({tag, "_wready"},  S_AXI_WREADY,  1'b0);
    checkBit({tag, "_bvalid"},  S_AXI_BVALID,  1'b0);
    checkOutput({tag, "_bresp"}, 32'(S_AXI_BRESP), 32'h0);
    checkBit({tag, "_arready"}, S_AXI_ARREADY, 1'b0);
    checkBit({tag, "_rvalid"},  S_AXI_RVALID,  1'b0);
    checkOutput({tag, "_rdata"}, S_AXI_RDATA, 32'h0);
    checkOutput({tag, "_rresp"}, 32'(S_AXI_RRESP), 32'h0);
    checkBit({tag, "_core_start"}, core_start, 1'b0);
    checkOutput({tag, "_core_rd_data"}, core_rd_data, 32'h0);
  endtask

  initial begin
    logic [1:0]  resp;
    logic [31:0] rd;
    int          s0;

    vecs[0]  = '{8'h08, 32'h0000_0001, 4'hF, 32'h0000_0001, 2'b00, 2'b00};
    vecs[1]  = '{8'h0C, 32'h0000_0002, 4'hF, 32'h0000_0002, 2'b00, 2'b00};
    vecs[2]  = '{8'h10, 32'h0000_0003, 4'hF, 32'h0000_0003, 2'b00, 2'b00};
    vecs[3]  = '{8'h14, 32'h0000_0004, 4'hF, 32'h0000_0004, 2'b00, 2'b00};
    vecs[4]  = '{8'h0C, 32'h1122_3344, 4'hF, 32'h1122_3344, 2'b00, 2'b00};
    vecs[5]  = '{8'h0C, 32'hAABB_CCDD, 4'h5, 32'h11BB_33DD, 2'b00, 2'b00};
    vecs[6]  = '{8'h1B, 32'h55AA_00FF, 4'hF, 32'h55AA_00FF, 2'b00, 2'b00};
    vecs[7]  = '{8'h3C, 32'hCAFE_F00D, 4'hF, 32'hCAFE_F00D, 2'b00, 2'b00};
    vecs[8]  = '{8'h00, 32'hABCD_0004, 4'hF, 32'hABCD_0004, 2'b00, 2'b00};
    vecs[9]  = '{8'h04, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000, 2'b00, 2'b00};
    vecs[10] = '{8'h40, 32'h1234_5678, 4'hF, 32'h0000_0000, 2'b10, 2'b10};
    vecs[11] = '{8'h00, 32'h0000_0003, 4'h0, 32'hABCD_0004, 2'b00, 2'b00};
    for (int i = 0; i < 16; i++) model_mem[i] = 32'h0;

    ARESET = 1'b1;
    S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
    core_busy = 1'b0; core_done = 1'b0; core_rd_addr = '0;

    $display("[TB] reset");
    repeat (3) tick();
    checkResetOutputs("reset");
    ARESET = 1'b0;
    tick();
    checkBit("post_reset_awready", S_AXI_AWREADY, 1'b1);
    checkBit("post_reset_wready",  S_AXI_WREADY,  1'b1);
    checkBit("post_reset_arready", S_AXI_ARREADY, 1'b1);

    $display("[TB] vector table");
    for (int i = 0; i < 12; i++) applyStimulus(i, vecs[i]);
    checkOutput("table_no_start", 32'(start_cnt), 32'h0);
    for (int i = 0; i < 16; i++) begin
      if (i != 1) readCheck($sformatf("unchanged_w%0d", i), 8'(i * 4), model_mem[i]);
    end

    $display("[TB] AW before W");
    S_AXI_AWADDR = 8'h08; S_AXI_AWVALID = 1'b1;
    checkBit("aw_first_awready_pre", S_AXI_AWREADY, 1'b1);
    tick();
    S_AXI_AWVALID = 1'b0;
    checkBit("aw_first_awready_drop", S_AXI_AWREADY, 1'b0);
    checkBit("aw_first_wready", S_AXI_WREADY, 1'b1);
    checkBit("aw_first_bvalid_early", S_AXI_BVALID, 1'b0);
    tick(); tick();
    S_AXI_WDATA = 32'hDEAD_BEEF; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    tick();
    S_AXI_WVALID = 1'b0;
    checkBit("aw_first_bvalid", S_AXI_BVALID, 1'b1);
    checkOutput("aw_first_bresp", 32'(S_AXI_BRESP), 32'h0);
    S_AXI_BREADY = 1'b1; tick(); S_AXI_BREADY = 1'b0;
    checkBit("aw_first_bvalid_clear", S_AXI_BVALID, 1'b0);
    model_write(8'h08, 32'hDEAD_BEEF, 4'hF);
    readCheck("aw_first_read", 8'h08, 32'hDEAD_BEEF);

    $display("[TB] W before AW");
    S_AXI_WDATA = 32'hFEED_FACE; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    tick();
    S_AXI_WVALID = 1'b0;
    checkBit("w_first_wready_drop", S_AXI_WREADY, 1'b0);
    checkBit("w_first_awready", S_AXI_AWREADY, 1'b1);
    checkBit("w_first_bvalid_early", S_AXI_BVALID, 1'b0);
    tick(); tick();
    S_AXI_AWADDR = 8'h08; S_AXI_AWVALID = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0;
    checkBit("w_first_bvalid", S_AXI_BVALID, 1'b1);
    S_AXI_BREADY = 1'b1; tick(); S_AXI_BREADY = 1'b0;
    model_write(8'h08, 32'hFEED_FACE, 4'hF);
    readCheck("w_first_read", 8'h08, 32'hFEED_FACE);

    $display("[TB] start and done");
    s0 = start_cnt;
    S_AXI_AWADDR = 8'h00; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = 32'h1; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    checkBit("start_pulse_high", core_start, 1'b1);
    checkBit("start_bvalid", S_AXI_BVALID, 1'b1);
    tick();
    checkBit("start_pulse_low", core_start, 1'b0);
    S_AXI_BREADY = 1'b1; tick(); S_AXI_BREADY = 1'b0;
    model_write(8'h00, 32'h1, 4'hF);
    checkOutput("start_pulse_count", 32'(start_cnt - s0), 32'h1);
    readCheck("ctrl_start_reads0", 8'h00, 32'h0);
    core_done = 1'b1; tick(); core_done = 1'b0;
    readCheck("status_done", 8'h04, 32'h2);
    core_busy = 1'b1;
    readCheck("status_done_busy", 8'h04, 32'h3);
    core_busy = 1'b0;
    S_AXI_AWADDR = 8'h00; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = 32'h2; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    core_done = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; core_done = 1'b0;
    S_AXI_BREADY = 1'b1; tick(); S_AXI_BREADY = 1'b0;
    model_write(8'h00, 32'h2, 4'hF);
    readCheck("status_set_wins", 8'h04, 32'h2);
    axi_write(8'h00, 32'h2, 4'hF, resp);
    checkOutput("done_clr_bresp", 32'(resp), 32'h0);
    readCheck("status_cleared", 8'h04, 32'h0);
    checkOutput("no_extra_start", 32'(start_cnt - s0), 32'h1);

    $display("[TB] core read port");
    core_rd_addr = 4'd2;
    tick();
    checkOutput("core_rd_w2", core_rd_data, 32'hFEED_FACE);
    S_AXI_AWADDR = 8'h08; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = 32'h0BAD_F00D; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    checkOutput("core_rd_after_commit", core_rd_data, 32'h0BAD_F00D);
    S_AXI_BREADY = 1'b1; tick(); S_AXI_BREADY = 1'b0;
    model_write(8'h08, 32'h0BAD_F00D, 4'hF);
    core_busy = 1'b1; core_rd_addr = 4'd1;
    tick();
    checkOutput("core_rd_status", core_rd_data, 32'h1);
    core_busy = 1'b0; core_rd_addr = 4'd15;
    tick();
    checkOutput("core_rd_w15", core_rd_data, 32'hCAFE_F00D);

    $display("[TB] read and write to the same word on one edge");
    S_AXI_AWADDR = 8'h10; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = 32'h77; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    S_AXI_ARADDR = 8'h10; S_AXI_ARVALID = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    checkBit("same_edge_rvalid", S_AXI_RVALID, 1'b1);
    checkOutput("same_edge_old_value", S_AXI_RDATA, 32'h3);
    checkBit("same_edge_bvalid", S_AXI_BVALID, 1'b1);
    S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1; tick();
    S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
    model_write(8'h10, 32'h77, 4'hF);
    readCheck("same_edge_new_value", 8'h10, 32'h77);

    $display("[TB] backpressure");
    S_AXI_AWADDR = 8'h14; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = 32'h99; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    S_AXI_ARADDR = 8'h0C; S_AXI_ARVALID = 1'b1;
    tick();
    S_AXI_WVALID = 1'b0;
    S_AXI_AWADDR = 8'h18; S_AXI_ARADDR = 8'h08;
    checkBit("bp_bvalid_start", S_AXI_BVALID, 1'b1);
    checkBit("bp_rvalid_start", S_AXI_RVALID, 1'b1);
    checkOutput("bp_rdata_start", S_AXI_RDATA, 32'h11BB_33DD);
    for (int c = 0; c < 5; c++) begin
      tick();
      checkBit($sformatf("bp_bvalid_c%0d", c), S_AXI_BVALID, 1'b1);
      checkBit($sformatf("bp_rvalid_c%0d", c), S_AXI_RVALID, 1'b1);
      checkOutput($sformatf("bp_rdata_c%0d", c), S_AXI_RDATA, 32'h11BB_33DD);
      checkBit($sformatf("bp_awready_c%0d", c), S_AXI_AWREADY, 1'b0);
      checkBit($sformatf("bp_arready_c%0d", c), S_AXI_ARREADY, 1'b0);
    end
    S_AXI_AWVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
    tick();
    S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
    checkBit("bp_bvalid_released", S_AXI_BVALID, 1'b0);
    checkBit("bp_rvalid_released", S_AXI_RVALID, 1'b0);
    model_write(8'h14, 32'h99, 4'hF);
    readCheck("bp_written", 8'h14, 32'h99);
    readCheck("bp_no_stray_write", 8'h18, 32'h55AA_00FF);

    $display("[TB] reset mid-write");
    core_done = 1'b1; tick(); core_done = 1'b0;
    S_AXI_AWADDR = 8'h20; S_AXI_AWVALID = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = 32'h5555_5555; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    ARESET = 1'b1;
    tick();
    checkResetOutputs("mid_reset");
    ARESET = 1'b0; S_AXI_WVALID = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      checkBit($sformatf("mid_reset_no_bvalid_c%0d", c), S_AXI_BVALID, 1'b0);
    end
    for (int i = 0; i < 16; i++) model_mem[i] = 32'h0;
    readCheck("mid_reset_dropped", 8'h20, 32'h0);
    readCheck("mid_reset_cleared", 8'h08, 32'h0);
    readCheck("mid_reset_done_clr", 8'h04, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
